// File: rtl/spmp_pkg.sv
// ============================================================================
// Module      : spmp_pkg
// Description : Shared types and the permission helper for the SPMP checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spmp_pkg;

    typedef enum logic [1:0] {
        SPMP_OFF   = 2'd0,
        SPMP_TOR   = 2'd1,
        SPMP_NA4   = 2'd2,
        SPMP_NAPOT = 2'd3
    } spmp_mode_e;

    typedef struct packed {
        logic       u;
        logic [1:0] rsvd;
        spmp_mode_e a;
        logic       x;
        logic       w;
        logic       r;
    } spmp_cfg_t;

    typedef logic [2:0] spmp_access_t;

    localparam spmp_access_t c_access_r = 3'b001;
    localparam spmp_access_t c_access_w = 3'b010;
    localparam spmp_access_t c_access_x = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } spmp_state_e;

    // A miss lets S-mode through and blocks U-mode.
    function automatic logic spmp_allow(input logic         hit,
                                        input spmp_cfg_t    cfg,
                                        input spmp_access_t access,
                                        input logic         priv_u);
        logic perm;
        logic result;
        perm = (cfg.r && access == c_access_r) ||
               (cfg.w && access == c_access_w) ||
               (cfg.x && access == c_access_x);
        if (!hit)
            result = !priv_u;
        else if (priv_u)
            result = cfg.u && perm;
        else
            result = !cfg.u && perm;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spmp_entry_match.sv
// ============================================================================
// Module      : spmp_entry_match
// Description : Combinational address match for a single SPMP entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spmp_entry_match
    import spmp_pkg::*;
#(
    parameter int PLEN = 56
) (
    input  wire logic [PLEN-3:0] i_addr,
    input  wire logic [PLEN-3:0] i_entry_addr,
    input  wire logic [PLEN-3:0] i_prev_addr,
    input  wire spmp_cfg_t       i_cfg,
    output logic                 o_match
);

    logic [PLEN-3:0] w_napot_mask;
    logic            w_unused_cfg;

    // Trailing ones plus the first zero form the don't-care field.
    assign w_napot_mask = ~(i_entry_addr ^ (i_entry_addr + 1'b1));
    assign w_unused_cfg = ^{i_cfg.u, i_cfg.rsvd, i_cfg.x, i_cfg.w, i_cfg.r};

    always_comb begin
        o_match = 1'b0;
        case (i_cfg.a)
            SPMP_TOR:   o_match = (i_addr >= i_prev_addr) && (i_addr < i_entry_addr);
            SPMP_NA4:   o_match = (i_addr == i_entry_addr);
            SPMP_NAPOT: o_match = ((i_addr ^ i_entry_addr) & w_napot_mask) == '0;
            default:    o_match = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/spmp_seq_checker.sv
// ============================================================================
// Module      : spmp_seq_checker
// Description : Sequential SPMP checker scanning EntriesPerCycle entries/clock.
//               Define SPMP_SEQ_CHECK_EARLY_EXIT_EN to stop at the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spmp_seq_checker
    import spmp_pkg::*;
#(
    parameter int NrEntries       = 64,
    parameter int EntriesPerCycle = 8,
    parameter int PLEN            = 56,
    localparam int IDX_W          = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic                      req_valid_i,
    output logic                           req_ready_o,
    input  wire logic [PLEN-1:0]           req_addr_i,
    input  wire logic [2:0]                req_access_i,
    input  wire logic                      req_priv_u_i,
    input  wire logic [NrEntries*8-1:0]    cfg_i,
    input  wire logic [NrEntries*(PLEN-2)-1:0] addr_i,
    input  wire logic                      cfg_changed_i,
    output logic                           resp_valid_o,
    input  wire logic                      resp_ready_i,
    output logic                           resp_allow_o,
    output logic                           resp_match_o,
    output logic [IDX_W-1:0]               resp_idx_o
);

    localparam int AW        = PLEN - 2;
    localparam int NR_CHUNKS = NrEntries / EntriesPerCycle;
    localparam int CHUNK_W   = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] c_last_chunk = CHUNK_W'(NR_CHUNKS - 1);

    spmp_state_e        r_state;
    logic [CHUNK_W-1:0] r_chunk;
    logic [AW-1:0]      r_addr;
    spmp_access_t       r_access;
    logic               r_priv_u;
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic               r_hit_allow;
    logic               r_resp_valid;
    logic               r_resp_allow;
    logic               r_resp_match;
    logic [IDX_W-1:0]   r_resp_idx;

    logic [AW-1:0]      w_addr_arr [NrEntries];
    logic               w_lane_match [EntriesPerCycle];
    logic [IDX_W-1:0]   w_lane_idx [EntriesPerCycle];
    spmp_cfg_t          w_lane_cfg [EntriesPerCycle];
    logic               w_chunk_hit;
    logic [IDX_W-1:0]   w_chunk_idx;
    spmp_cfg_t          w_chunk_cfg;
    logic               w_chunk_allow;
    logic               w_last;
    logic               w_done;
    logic               w_sel_hit;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_allow;
    logic               w_unused_addr;

    assign w_unused_addr = ^req_addr_i[1:0];

    for (genvar i = 0; i < NrEntries; i++) begin : g_unpack
        assign w_addr_arr[i] = addr_i[i*AW +: AW];
    end

    for (genvar j = 0; j < EntriesPerCycle; j++) begin : g_lane
        logic [AW-1:0] w_prev;

        assign w_lane_idx[j] = IDX_W'(r_chunk * EntriesPerCycle + j);
        assign w_lane_cfg[j] = spmp_cfg_t'(cfg_i[w_lane_idx[j]*8 +: 8]);
        // TOR lower bound comes from the neighbour even when it sits in another chunk.
        assign w_prev = (w_lane_idx[j] == '0) ? '0 : w_addr_arr[w_lane_idx[j] - 1'b1];

        spmp_entry_match #(
            .PLEN (PLEN)
        ) u_entry_match (
            .i_addr       (r_addr),
            .i_entry_addr (w_addr_arr[w_lane_idx[j]]),
            .i_prev_addr  (w_prev),
            .i_cfg        (w_lane_cfg[j]),
            .o_match      (w_lane_match[j])
        );
    end

    always_comb begin
        w_chunk_hit = 1'b0;
        w_chunk_idx = '0;
        w_chunk_cfg = '0;
        for (int j = EntriesPerCycle - 1; j >= 0; j--) begin
            if (w_lane_match[j]) begin
                w_chunk_hit = 1'b1;
                w_chunk_idx = w_lane_idx[j];
                w_chunk_cfg = w_lane_cfg[j];
            end
        end
    end

    assign w_chunk_allow = spmp_allow(w_chunk_hit, w_chunk_cfg, r_access, r_priv_u);
    assign w_last        = (r_chunk == c_last_chunk);

    // A hit held from an earlier chunk outranks anything found now.
    assign w_sel_hit   = r_hit | w_chunk_hit;
    assign w_sel_idx   = r_hit ? r_hit_idx   : w_chunk_idx;
    assign w_sel_allow = r_hit ? r_hit_allow : w_chunk_allow;

`ifdef SPMP_SEQ_CHECK_EARLY_EXIT_EN
    assign w_done = w_chunk_hit | w_last;
`else
    assign w_done = w_last;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_chunk      <= '0;
            r_addr       <= '0;
            r_access     <= '0;
            r_priv_u     <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_idx    <= '0;
            r_hit_allow  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_allow <= 1'b0;
            r_resp_match <= 1'b0;
            r_resp_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr   <= req_addr_i[PLEN-1:2];
                        r_access <= req_access_i;
                        r_priv_u <= req_priv_u_i;
                        r_chunk  <= '0;
                        r_hit    <= 1'b0;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cfg_changed_i) begin
                        r_chunk <= '0;
                        r_hit   <= 1'b0;
                    end else if (w_done) begin
                        r_resp_valid <= 1'b1;
                        r_resp_allow <= w_sel_allow;
                        r_resp_match <= w_sel_hit;
                        r_resp_idx   <= w_sel_hit ? w_sel_idx : '0;
                        r_state      <= ST_RESP;
                    end else begin
                        if (w_chunk_hit && !r_hit) begin
                            r_hit       <= 1'b1;
                            r_hit_idx   <= w_chunk_idx;
                            r_hit_allow <= w_chunk_allow;
                        end
                        r_chunk <= r_chunk + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE);
    assign resp_valid_o = r_resp_valid;
    assign resp_allow_o = r_resp_allow;
    assign resp_match_o = r_resp_match;
    assign resp_idx_o   = r_resp_idx;

endmodule

`default_nettype wire

// File: tb/tb_spmp_seq_checker.sv
// ============================================================================
// Module      : tb_spmp_seq_checker
// Description : Self-checking bench for spmp_seq_checker (64 entries, 8/cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spmp_seq_checker;

    localparam int NR   = 64;
    localparam int EPC  = 8;
    localparam int PLEN = 56;
    localparam int AW   = PLEN - 2;
    localparam int NCH  = NR / EPC;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [PLEN-1:0]      req_addr_i;
    logic [2:0]           req_access_i;
    logic                 req_priv_u_i;
    logic [NR*8-1:0]      cfg_v;
    logic [NR*AW-1:0]     addr_v;
    logic                 cfg_changed_i;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic                 resp_allow_o;
    logic                 resp_match_o;
    logic [5:0]           resp_idx_o;

    spmp_seq_checker #(
        .NrEntries       (NR),
        .EntriesPerCycle (EPC),
        .PLEN            (PLEN)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_access_i  (req_access_i),
        .req_priv_u_i  (req_priv_u_i),
        .cfg_i         (cfg_v),
        .addr_i        (addr_v),
        .cfg_changed_i (cfg_changed_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_allow_o  (resp_allow_o),
        .resp_match_o  (resp_match_o),
        .resp_idx_o    (resp_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          e0;
        logic [7:0]  c0;
        logic [53:0] a0;
        int          e1;
        logic [7:0]  c1;
        logic [53:0] a1;
        logic [55:0] ra;
        logic [2:0]  acc;
        logic        u;
        logic        ea;
        logic        em;
        logic [5:0]  ei;
    } vec_t;

    typedef struct {
        logic       allow;
        logic       match;
        logic [5:0] idx;
        int         lat;
    } exp_t;

    vec_t vecs [13];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", name, id, got, want);
        end
    endtask

    function automatic int exp_lat(input logic m, input logic [5:0] idx);
`ifdef SPMP_SEQ_CHECK_EARLY_EXIT_EN
        return m ? (int'(idx) / EPC + 1) : NCH;
`else
        return NCH;
`endif
    endfunction

    task automatic program_cfg(input vec_t v);
        cfg_v  = '0;
        addr_v = '0;
        if (v.e0 >= 0) begin
            cfg_v[v.e0*8 +: 8]   = v.c0;
            addr_v[v.e0*AW +: AW] = v.a0;
        end
        if (v.e1 >= 0) begin
            cfg_v[v.e1*8 +: 8]   = v.c1;
            addr_v[v.e1*AW +: AW] = v.a1;
        end
    endtask

    task automatic issue(input int id, input logic [55:0] a, input logic [2:0] acc, input logic u);
        int w = 0;
        while (!req_ready_o && w < 50) begin
            @(posedge clk_i); #1;
            w++;
        end
        chk("ready_before_req", id, req_ready_o, 1);
        req_addr_i   = a;
        req_access_i = acc;
        req_priv_u_i = u;
        req_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i  = 1'b0;
    endtask

    task automatic collect(input int id, input int n);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", id, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("resp_valid", id, resp_valid_o, 1);
        chk("latency", id, n, e.lat);
        chk("allow", id, resp_allow_o, e.allow);
        chk("match", id, resp_match_o, e.match);
        chk("idx", id, resp_idx_o, e.idx);
        chk("ready_in_resp", id, req_ready_o, 0);
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        chk("valid_after_take", id, resp_valid_o, 0);
        chk("ready_after_take", id, req_ready_o, 1);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        exp_t e;

        // {e0, cfg0, addr0, e1, cfg1, addr1, req addr, access, U, allow, match, idx}
        vecs[0]  = '{3,  8'h99, 54'h2000_01FF, -1, 8'h00, 54'h0,   56'h8000_0010, 3'b001, 1'b1, 1'b1, 1'b1, 6'd3};
        vecs[1]  = '{60, 8'h0C, 54'h800,       59, 8'h00, 54'h400, 56'h1800,      3'b100, 1'b0, 1'b1, 1'b1, 6'd60};
        vecs[2]  = '{10, 8'h92, 54'h1000,      12, 8'h91, 54'h1000, 56'h4000,     3'b001, 1'b1, 1'b0, 1'b1, 6'd10};
        vecs[3]  = '{-1, 8'h00, 54'h0,         -1, 8'h00, 54'h0,   56'h0,         3'b001, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[4]  = '{-1, 8'h00, 54'h0,         -1, 8'h00, 54'h0,   56'h0,         3'b001, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{3,  8'h99, 54'h2000_01FF, -1, 8'h00, 54'h0,   56'h8000_0010, 3'b001, 1'b0, 1'b0, 1'b1, 6'd3};
        vecs[6]  = '{3,  8'h99, 54'h2000_01FF, -1, 8'h00, 54'h0,   56'h8000_0FFC, 3'b010, 1'b1, 1'b0, 1'b1, 6'd3};
        vecs[7]  = '{3,  8'h99, 54'h2000_01FF, -1, 8'h00, 54'h0,   56'h8000_1000, 3'b001, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[8]  = '{60, 8'h0C, 54'h800,       59, 8'h00, 54'h400, 56'h2000,      3'b100, 1'b0, 1'b1, 1'b0, 6'd0};
        vecs[9]  = '{60, 8'h0C, 54'h800,       59, 8'h00, 54'h400, 56'h1000,      3'b100, 1'b0, 1'b1, 1'b1, 6'd60};
        vecs[10] = '{0,  8'h09, 54'h400,       -1, 8'h00, 54'h0,   56'h0FFC,      3'b001, 1'b0, 1'b1, 1'b1, 6'd0};
        vecs[11] = '{8,  8'h12, 54'h888,       -1, 8'h00, 54'h0,   56'h2220,      3'b010, 1'b0, 1'b1, 1'b1, 6'd8};
        vecs[12] = '{16, 8'h8C, 54'h1000,      15, 8'h00, 54'hC00, 56'h3FFC,      3'b100, 1'b1, 1'b1, 1'b1, 6'd16};

        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_access_i = '0;
        req_priv_u_i = 1'b0; cfg_v = '0; addr_v = '0; cfg_changed_i = 1'b0; resp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_req_ready", 0, req_ready_o, 1);
        chk("reset_resp_valid", 0, resp_valid_o, 0);
        chk("reset_resp_allow", 0, resp_allow_o, 0);
        chk("reset_resp_match", 0, resp_match_o, 0);
        chk("reset_resp_idx", 0, resp_idx_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 13; i++) begin
            program_cfg(vecs[i]);
            e = '{vecs[i].ea, vecs[i].em, vecs[i].ei, exp_lat(vecs[i].em, vecs[i].ei)};
            sb.push_back(e);
            issue(i, vecs[i].ra, vecs[i].acc, vecs[i].u);
            wait_resp(n);
            collect(i, n);
        end

        // Restart: entry 50 is enabled together with a cfg_changed pulse in the third scan cycle.
        cfg_v = '0;
        addr_v = '0;
        addr_v[50*AW +: AW] = 54'h1400;
        e = '{1'b1, 1'b1, 6'd50, exp_lat(1'b1, 6'd50) + 3};
        sb.push_back(e);
        issue(100, 56'h5000, 3'b001, 1'b1);
        n = 0;
        while (!resp_valid_o && n < 40) begin
            if (n == 2) begin
                cfg_v[50*8 +: 8] = 8'h91;
                cfg_changed_i = 1'b1;
            end
            @(posedge clk_i); #1;
            cfg_changed_i = 1'b0;
            n++;
        end
        collect(100, n);

        // Stalled response, then asynchronous reset in the middle of RESP.
        program_cfg(vecs[0]);
        issue(200, 56'h8000_0010, 3'b001, 1'b1);
        wait_resp(n);
        chk("stall_latency", 200, n, exp_lat(1'b1, 6'd3));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            chk("stall_valid", 200 + k, resp_valid_o, 1);
            chk("stall_allow", 200 + k, resp_allow_o, 1);
            chk("stall_idx", 200 + k, resp_idx_o, 3);
        end
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 210, resp_valid_o, 0);
        chk("async_rst_allow", 210, resp_allow_o, 0);
        chk("async_rst_match", 210, resp_match_o, 0);
        chk("async_rst_idx", 210, resp_idx_o, 0);
        chk("async_rst_ready", 210, req_ready_o, 1);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_valid", 211, resp_valid_o, 0);
        chk("post_rst_ready", 211, req_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spmp_seq_checker.md
# spmp_seq_checker

- Sequential S-mode PMP (SPMP) region checker for the CVA6 load/store and fetch paths.
- Scans `NrEntries` SPMP entries in chunks of `EntriesPerCycle` per clock instead of matching all entries in parallel, trading latency for area at large entry counts (64 entries).
- Returns allow/deny, match flag and the index of the lowest-numbered matching entry.
- Sits between the address-translation stage and the memory request issue point.

## Interface

Parameters:
- `NrEntries`, default 64: number of SPMP entries; ≥1.
- `EntriesPerCycle`, default 8: entries evaluated per scan cycle; must divide `NrEntries`.
- `PLEN`, default 56: physical address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `req_valid_i`  in  1  check request.
- `req_ready_o`  out  1  checker can accept a request.
- `req_addr_i`  in  PLEN  physical byte address.
- `req_access_i`  in  3  one-hot access type: bit0 R, bit1 W, bit2 X.
- `req_priv_u_i`  in  1  1 = U-mode access, 0 = S-mode access.
- `cfg_i`  in  NrEntries×8  per-entry cfg: [0] R, [1] W, [2] X, [4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [7] U.
- `addr_i`  in  NrEntries×(PLEN-2)  per-entry address register (byte address >> 2).
- `cfg_changed_i`  in  1  pulse: cfg or addr changed this cycle.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  consumer takes the result.
- `resp_allow_o`  out  1  access permitted.
- `resp_match_o`  out  1  some entry matched.
- `resp_idx_o`  out  max(1,$clog2(NrEntries))  lowest matching index; 0 if no match.

## Operation

FSM states:
- IDLE: `req_ready_o`=1. On `req_valid_i`, latch addr/access/priv, clear the chunk counter, go to SCAN.
- SCAN: evaluate chunk `c` (entries c·EPC … c·EPC+EPC-1).
  - A match in the chunk (with early exit) or the last chunk: latch the result and go to RESP.
  - Otherwise c++.
  - Without early exit, the first match found is held and the scan always continues to the last chunk.
- RESP: hold outputs stable until `resp_ready_i`, then go to IDLE.

Entry matching, with a = latched addr >> 2:
- OFF: never matches.
- NA4: a == addr[i].
- NAPOT: compare a with addr[i] after masking the low (trailing-ones+1) bits.
- TOR: addr[i-1] ≤ a < addr[i]; entry 0 uses a lower bound of 0. addr[i-1] is always read from `addr_i`, including across chunk boundaries.
- Within a chunk the lowest index wins. Earlier chunks win over later ones.

Permission rules:
- Match, U-mode: allow only if cfg.U=1 and the requested R/W/X bit is set.
- Match, S-mode: deny if cfg.U=1; otherwise allow if the requested bit is set.
- No match: S-mode allowed, U-mode denied.

Boundary behaviour:
- `cfg_changed_i` in SCAN: restart at chunk 0 next cycle and discard any held partial match.
- `cfg_changed_i` in IDLE or RESP: ignored.
- `NrEntries == EntriesPerCycle`: single scan cycle.
- Reset in any state: immediate return to IDLE; the in-flight request is dropped.

## Timing

- Request accepted at clock edge E. First match in chunk k ⇒ `resp_valid_o` high after edge E+k+1 (early exit). Worst case is E+NrEntries/EntriesPerCycle.
- Every `cfg_changed_i` in SCAN adds a full restart.
- `req_ready_o` is combinational from state only. No request is accepted in the cycle RESP completes; the next accept is earliest the following cycle.
- Reset values: `req_ready_o`=1; `resp_valid_o`, `resp_allow_o`, `resp_match_o` and `resp_idx_o` all 0.
- All response outputs are registered.

## Configuration

`SPMP_SEQ_CHECK_EARLY_EXIT_EN`:
- Defined: SCAN ends at the first chunk containing a match; latency depends on the matching index.
- Undefined: every check scans all chunks. Latency is constantly NrEntries/EntriesPerCycle edges, with no timing side channel. Results are identical in both builds.

## Structure

- Shared package `spmp_pkg`:
  - `spmp_cfg_t` (packed cfg struct).
  - `spmp_mode_e` (OFF/TOR/NA4/NAPOT).
  - `spmp_access_t` one-hot constants.
  - FSM state enum.
- Sub-module `spmp_entry_match`: combinational single-entry matcher taking the address, `addr[i]`, `addr[i-1]` and cfg. It is instantiated `EntriesPerCycle` times and fed by a chunk-counter mux.

## Test plan

Configuration for all scenarios: NrEntries=64, EPC=8.

1. Entry 3 NAPOT base 0x8000_0000 size 4 KiB (R=1, U=1); U-mode read of 0x8000_0010 → allow=1, match=1, idx=3, resp after E+1.
2. Only entry 60 TOR [0x1000,0x2000) (X=1, U=0); S-mode exec of 0x1800 → allow=1, idx=60. Latency E+8; the same latency holds with the macro undefined.
3. Entries 10 and 12 both match 0x4000 (10: R=0; 12: R=1, both U=1); U read → allow=0, idx=10.
4. No entries enabled: S read of 0x0 → allow=1, match=0; U read → allow=0, match=0, idx=0.
5. `cfg_changed_i` pulsed in the 3rd SCAN cycle while entry 50 is being enabled → scan restarts; final idx=50 and latency grows by 3 cycles.
6. `resp_ready_i` held low for 5 cycles, then `rst_i` asserted mid-RESP → outputs held stable, then all outputs go to their reset values asynchronously; `req_ready_o`=1.
